// File: rtl/skin_bbox_overlay.sv
`default_nettype none
// ============================================================================
//  Module   : skin_bbox_overlay
//  Purpose  : Measures the bounding box of skin pixels in each frame of the
//             keyed skin-filter stream. Exports the box as status and draws
//             it as a border on the following frame.
//  Revision : 1.0  initial release
// ============================================================================
module skin_bbox_overlay #(
    parameter logic [23:0] KEY_COLOR  = 24'hFF00FF,
    parameter logic [23:0] BOX_COLOR  = 24'h00FF00,
    parameter int          BOX_W      = 2,
    parameter int          MIN_PIXELS = 64,
    parameter int          CW         = 12,
    parameter int          NW         = 21
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [23:0]   i_vid_data,
    input  logic          i_vid_hsync,
    input  logic          i_vid_vsync,
    input  logic          i_vid_VDE,
    input  logic          i_en,
    output logic [23:0]   o_vid_data,
    output logic          o_vid_hsync,
    output logic          o_vid_vsync,
    output logic          o_vid_VDE,
    output logic          o_box_valid,
    output logic [CW-1:0] o_xmin,
    output logic [CW-1:0] o_xmax,
    output logic [CW-1:0] o_ymin,
    output logic [CW-1:0] o_ymax
);

    localparam logic [NW-1:0] MIN_CNT   = NW'(MIN_PIXELS);
    localparam logic [CW-1:0] BOX_W_C   = CW'(BOX_W);
    localparam logic [CW-1:0] COORD_MAX = '1;
    localparam logic [NW-1:0] COUNT_MAX = '1;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        LATCH = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          latch_now;

    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [NW-1:0] count;
    logic          prev_vde;
    logic          prev_vsync;
    logic [CW-1:0] min_x;
    logic [CW-1:0] max_x;
    logic [CW-1:0] min_y;
    logic [CW-1:0] max_y;

    logic          vde_fall;
    logic          vsync_rise;
    logic          skin;
    logic          in_box;
    logic          on_border;
    logic          draw;

    assign vde_fall   = prev_vde & ~i_vid_VDE;
    assign vsync_rise = i_vid_vsync & ~prev_vsync;
    assign skin       = i_vid_VDE && (i_vid_data != KEY_COLOR);

    // Edge-detect history for VDE and vsync
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_vde   <= 1'b0;
            prev_vsync <= 1'b0;
        end else begin
            prev_vde   <= i_vid_VDE;
            prev_vsync <= i_vid_vsync;
        end
    end

    // Saturating pixel coordinates of the current input pixel
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x <= '0;
            y <= '0;
        end else begin
            if (vde_fall)
                x <= '0;
            else if (i_vid_VDE && (x != COORD_MAX))
                x <= x + 1'b1;

            if (vsync_rise)
                y <= '0;
            else if (vde_fall && (y != COORD_MAX))
                y <= y + 1'b1;
        end
    end

    // Frame latch state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= ACCUM;
        else
            state <= state_next;
    end

    // Latch on the vsync rising edge; LATCH marks the one-cycle handover
    always_comb begin
        state_next = state;
        latch_now  = 1'b0;
        case (state)
            ACCUM: begin
                if (vsync_rise) begin
                    latch_now  = 1'b1;
                    state_next = LATCH;
                end
            end
            LATCH:   state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Bounding-box accumulators; a pixel on the latch cycle seeds the new frame
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
            count <= '0;
        end else if (latch_now) begin
            min_x <= skin ? x : '1;
            max_x <= skin ? x : '0;
            min_y <= skin ? y : '1;
            max_y <= skin ? y : '0;
            count <= skin ? NW'(1) : '0;
        end else if (skin) begin
            if (x < min_x) min_x <= x;
            if (x > max_x) max_x <= x;
            if (y < min_y) min_y <= y;
            if (y > max_y) max_y <= y;
            if (count != COUNT_MAX) count <= count + 1'b1;
        end
    end

    // Status outputs; coordinates hold when the frame had too few skin pixels
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_box_valid <= 1'b0;
            o_xmin      <= '0;
            o_xmax      <= '0;
            o_ymin      <= '0;
            o_ymax      <= '0;
        end else if (latch_now) begin
            if (count >= MIN_CNT) begin
                o_box_valid <= 1'b1;
                o_xmin      <= min_x;
                o_xmax      <= max_x;
                o_ymin      <= min_y;
                o_ymax      <= max_y;
            end else begin
                o_box_valid <= 1'b0;
            end
        end
    end

    // Border test against the previously latched box
    always_comb begin
        in_box    = (x >= o_xmin) && (x <= o_xmax) && (y >= o_ymin) && (y <= o_ymax);
        on_border = 1'b0;
        if (in_box) begin
            on_border = (CW'(x - o_xmin) < BOX_W_C) || (CW'(o_xmax - x) < BOX_W_C) ||
                        (CW'(y - o_ymin) < BOX_W_C) || (CW'(o_ymax - y) < BOX_W_C);
        end
        draw = i_en && i_vid_VDE && o_box_valid && in_box && on_border;
    end

    // One-cycle video pipeline with overlay substitution
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_vid_data  <= '0;
            o_vid_hsync <= 1'b0;
            o_vid_vsync <= 1'b0;
            o_vid_VDE   <= 1'b0;
        end else begin
            o_vid_data  <= draw ? BOX_COLOR : i_vid_data;
            o_vid_hsync <= i_vid_hsync;
            o_vid_vsync <= i_vid_vsync;
            o_vid_VDE   <= i_vid_VDE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_skin_bbox_overlay.sv
`default_nettype none
// ============================================================================
//  Module   : tb_skin_bbox_overlay
//  Purpose  : Directed self-checking bench for skin_bbox_overlay using
//             16x8 frames, MIN_PIXELS=4 and BOX_W=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_skin_bbox_overlay;

    localparam logic [23:0] KEY   = 24'hFF00FF;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] SKIN  = 24'h806040;

    logic        clk;
    logic        n_rst;
    logic [23:0] vid_data;
    logic        vid_hsync;
    logic        vid_vsync;
    logic        vid_vde;
    logic        en;
    logic [23:0] o_vid_data;
    logic        o_vid_hsync;
    logic        o_vid_vsync;
    logic        o_vid_VDE;
    logic        o_box_valid;
    logic [11:0] o_xmin;
    logic [11:0] o_xmax;
    logic [11:0] o_ymin;
    logic [11:0] o_ymax;

    int compared;
    int mismatched;

    skin_bbox_overlay #(
        .KEY_COLOR  (KEY),
        .BOX_COLOR  (GREEN),
        .BOX_W      (1),
        .MIN_PIXELS (4),
        .CW         (12),
        .NW         (21)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_vid_data  (vid_data),
        .i_vid_hsync (vid_hsync),
        .i_vid_vsync (vid_vsync),
        .i_vid_VDE   (vid_vde),
        .i_en        (en),
        .o_vid_data  (o_vid_data),
        .o_vid_hsync (o_vid_hsync),
        .o_vid_vsync (o_vid_vsync),
        .o_vid_VDE   (o_vid_VDE),
        .o_box_valid (o_box_valid),
        .o_xmin      (o_xmin),
        .o_xmax      (o_xmax),
        .o_ymin      (o_ymin),
        .o_ymax      (o_ymax)
    );

    // 100 MHz pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_box(input string tag, input logic v, input int x0, input int x1,
                             input int y0, input int y1);
        check({tag, ".valid"}, 32'(o_box_valid), 32'(v));
        check({tag, ".xmin"},  32'(o_xmin), 32'(x0));
        check({tag, ".xmax"},  32'(o_xmax), 32'(x1));
        check({tag, ".ymin"},  32'(o_ymin), 32'(y0));
        check({tag, ".ymax"},  32'(o_ymax), 32'(y1));
    endtask

    // Drive one pixel at the falling edge, check its registered output after the rising edge
    task automatic drive_cycle(input logic [23:0] d, input logic h, input logic v,
                               input logic de, input logic [23:0] exp_d);
        vid_data  = d;
        vid_hsync = h;
        vid_vsync = v;
        vid_vde   = de;
        @(posedge clk);
        #1;
        check("vid_data", 32'(o_vid_data), 32'(exp_d));
        check("vid_vde",  32'(o_vid_VDE), 32'(de));
        check("vid_hs",   32'(o_vid_hsync), 32'(h));
        check("vid_vs",   32'(o_vid_vsync), 32'(v));
        @(negedge clk);
    endtask

    // 0: all key, 1: 3x3 block at 5..7/2..4, 2: two lone pixels, 3: 3x3 block at 9..11/4..6
    function automatic logic [23:0] pix(input int mode, input int x, input int y);
        case (mode)
            1: return (x >= 5 && x <= 7 && y >= 2 && y <= 4) ? SKIN : KEY;
            2: return ((x == 3 && y == 1) || (x == 12 && y == 6)) ? SKIN : KEY;
            3: return (x >= 9 && x <= 11 && y >= 4 && y <= 6) ? SKIN : KEY;
            default: return KEY;
        endcase
    endfunction

    task automatic blank_cycles(input int n);
        for (int k = 0; k < n; k++) drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    // One 16x8 frame followed by a vsync pulse; border expected on the given box when draw=1
    task automatic run_frame(input int mode, input logic en_v, input logic draw,
                             input int bx0, input int bx1, input int by0, input int by1);
        logic [23:0] d;
        logic        brd;
        en = en_v;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                d   = pix(mode, x, y);
                brd = draw && x >= bx0 && x <= bx1 && y >= by0 && y <= by1 &&
                      (x == bx0 || x == bx1 || y == by0 || y == by1);
                drive_cycle(d, 1'b0, 1'b0, 1'b1, brd ? GREEN : d);
            end
            for (int k = 0; k < 4; k++)
                drive_cycle(24'h0, (k == 1 || k == 2), 1'b0, 1'b0, 24'h0);
        end
        blank_cycles(2);
        drive_cycle(24'h0, 1'b0, 1'b1, 1'b0, 24'h0);
        drive_cycle(24'h0, 1'b0, 1'b1, 1'b0, 24'h0);
        blank_cycles(3);
    endtask

    // Directed sequence
    initial begin
        compared   = 0;
        mismatched = 0;
        n_rst      = 1'b0;
        vid_data   = 24'h0;
        vid_hsync  = 1'b0;
        vid_vsync  = 1'b0;
        vid_vde    = 1'b0;
        en         = 1'b1;
        #1;
        check("rst.vid_data", 32'(o_vid_data), 32'h0);
        check("rst.vid_vde",  32'(o_vid_VDE), 32'h0);
        check_box("rst", 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        blank_cycles(2);

        // A: no skin at all -> invalid, passthrough
        run_frame(0, 1'b1, 1'b0, 0, 0, 0, 0);
        check_box("frameA", 1'b0, 0, 0, 0, 0);

        // B: 3x3 block measured; nothing drawn yet
        run_frame(1, 1'b1, 1'b0, 0, 0, 0, 0);
        check_box("frameB", 1'b1, 5, 7, 2, 4);

        // C: same block, border drawn from previous measurement
        run_frame(1, 1'b1, 1'b1, 5, 7, 2, 4);
        check_box("frameC", 1'b1, 5, 7, 2, 4);

        // D: overlay disabled, tracking still updates to a shifted block
        run_frame(3, 1'b0, 1'b0, 0, 0, 0, 0);
        check_box("frameD", 1'b1, 9, 11, 4, 6);

        // E: stale box from D drawn while the original block is measured
        run_frame(1, 1'b1, 1'b1, 9, 11, 4, 6);
        check_box("frameE", 1'b1, 5, 7, 2, 4);

        // F: only two skin pixels -> invalid, coordinates held
        run_frame(2, 1'b1, 1'b1, 5, 7, 2, 4);
        check_box("frameF", 1'b0, 5, 7, 2, 4);

        // G: no border after an invalid frame
        run_frame(1, 1'b1, 1'b0, 0, 0, 0, 0);
        check_box("frameG", 1'b1, 5, 7, 2, 4);

        // Reset mid-line after a full line of skin outside the drawn box
        for (int x = 0; x < 16; x++) drive_cycle(SKIN, 1'b0, 1'b0, 1'b1, SKIN);
        blank_cycles(4);
        for (int x = 0; x < 8; x++) drive_cycle(SKIN, 1'b0, 1'b0, 1'b1, SKIN);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst.vid_data", 32'(o_vid_data), 32'h0);
        check("arst.vid_vde",  32'(o_vid_VDE), 32'h0);
        check_box("arst", 1'b0, 0, 0, 0, 0);
        vid_data = 24'h0;
        vid_vde  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        blank_cycles(4);

        // H: only post-reset pixels are latched
        run_frame(1, 1'b1, 1'b0, 0, 0, 0, 0);
        check_box("frameH", 1'b1, 5, 7, 2, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
